// File: rtl/frame_irq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_irq_pkg
// Description : Shared field positions, widths and mode encodings for the
//               frame-gated key interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_irq_pkg;

    // Interrupt instruction layout
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 27;
    localparam int CH_IDX_MSB  = 26;
    localparam int CH_IDX_LSB  = 22;
    localparam int FRAME_MSB   = 21;
    localparam int FRAME_LSB   = 0;

    localparam int CH_IDX_W    = 5;
    localparam int FRAME_CNT_W = 22;
    localparam int DROP_CNT_W  = 8;

    localparam logic [4:0] IRQ_OPCODE_DEFAULT = 5'b11110;

    // Per-channel mode encodings for ch_repeat
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_REPEAT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/irq_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irq_sync_fifo
// Description : Single-clock FIFO with full/empty flags. A push while full is
//               accepted when a pop happens in the same cycle.
// Ports       : clk, reset_n (async active-low), i_push/i_wdata write side,
//               i_pop read side, o_rdata head entry, o_full, o_empty.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/frame_irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_irq_controller
// Description : Synchronises, debounces and edge-detects NUM_CH key inputs,
//               gates events to frame_tick boundaries and queues them as
//               32-bit interrupt instructions behind a valid/ack handshake.
// Ports       : clk, reset_n (async active-low), keys, ch_enable, ch_repeat,
//               frame_tick, irq_ack in; interrupt_instruction, irq_valid,
//               overflow (sticky), drop_count (saturating) out.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_irq_controller
    import frame_irq_pkg::*;
#(
    parameter int         NUM_CH          = 4,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         FIFO_DEPTH      = 8,
    parameter logic [4:0] IRQ_OPCODE      = IRQ_OPCODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     keys,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     ch_repeat,
    input  logic                  frame_tick,
    input  logic                  irq_ack,
    output logic [31:0]           interrupt_instruction,
    output logic                  irq_valid,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int                DB_CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_CNT_W-1:0] c_db_last = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0]      r_key_meta;
    logic [NUM_CH-1:0]      r_key_sync;
    logic [NUM_CH-1:0]      r_key_deb;
    logic [DB_CNT_W-1:0]    r_db_cnt [NUM_CH];
    logic                   r_tick_meta;
    logic                   r_tick_sync;
    logic                   r_tick_prev;
    logic [NUM_CH-1:0]      r_pending;
    logic [NUM_CH-1:0]      r_batch;
    logic [FRAME_CNT_W-1:0] r_batch_frame;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_overflow;
    logic [DROP_CNT_W-1:0]  r_drop_count;

    logic                   w_tick;
    logic [NUM_CH-1:0]      w_deb_rise;
    logic [NUM_CH-1:0]      w_repeat_mask;
    logic [NUM_CH-1:0]      w_events;
    logic [NUM_CH-1:0]      w_snapshot;
    logic [NUM_CH-1:0]      w_sel_onehot;
    logic [CH_IDX_W-1:0]    w_sel_idx;
    logic [31:0]            w_push_data;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [31:0]            w_fifo_rdata;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    // ---------------- Key synchronisers and debounce ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_meta <= '0;
            r_key_sync <= '0;
            r_key_deb  <= '0;
            for (int i = 0; i < NUM_CH; i++) r_db_cnt[i] <= '0;
        end else begin
            r_key_meta <= keys;
            r_key_sync <= r_key_meta;
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_key_sync[i] == r_key_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_db_last) begin
                    r_key_deb[i] <= r_key_sync[i];
                    r_db_cnt[i]  <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge is flagged in the cycle the debounced state is about to
    // flip, so an edge coinciding with a tick lands in that frame's batch.
    always_comb begin
        w_deb_rise    = '0;
        w_repeat_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_deb_rise[i]    = r_key_sync[i] & ~r_key_deb[i] & (r_db_cnt[i] == c_db_last);
            w_repeat_mask[i] = (ch_repeat[i] == MODE_REPEAT);
        end
    end

    // ---------------- Frame tick synchroniser and edge detect ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_meta <= 1'b0;
            r_tick_sync <= 1'b0;
            r_tick_prev <= 1'b0;
        end else begin
            r_tick_meta <= frame_tick;
            r_tick_sync <= r_tick_meta;
            r_tick_prev <= r_tick_sync;
        end
    end

    assign w_tick     = r_tick_sync & ~r_tick_prev;
    assign w_events   = ch_enable & (w_deb_rise | ({NUM_CH{w_tick}} & r_key_deb & w_repeat_mask));
    assign w_snapshot = r_pending | w_events;

    // ---------------- Arbiter: lowest set batch bit wins ----------------
    assign w_sel_onehot = r_batch & (~r_batch + NUM_CH'(1));
    assign w_push       = |r_batch;

    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_batch[i]) w_sel_idx = CH_IDX_W'(i);
        end
    end

    always_comb begin
        w_push_data                         = '0;
        w_push_data[OPCODE_MSB:OPCODE_LSB]  = IRQ_OPCODE;
        w_push_data[CH_IDX_MSB:CH_IDX_LSB]  = w_sel_idx;
        w_push_data[FRAME_MSB:FRAME_LSB]    = r_batch_frame;
    end

    // ---------------- Pending, batch, frame counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending     <= '0;
            r_batch       <= '0;
            r_batch_frame <= '0;
            r_frame_count <= '0;
        end else begin
            r_pending     <= w_tick ? '0 : w_snapshot;
            // A new snapshot merges into whatever is still being drained
            r_batch       <= (r_batch & ~w_sel_onehot) | (w_tick ? w_snapshot : '0);
            if (w_tick) r_batch_frame <= r_frame_count;
            r_frame_count <= r_frame_count + FRAME_CNT_W'(w_tick);
        end
    end

    // ---------------- Queue and drop accounting ----------------
    assign w_pop  = irq_ack & ~w_fifo_empty;
    assign w_drop = w_push & w_fifo_full & ~w_pop;

    irq_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != {DROP_CNT_W{1'b1}}) r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign irq_valid             = ~w_fifo_empty;
    assign interrupt_instruction = w_fifo_empty ? 32'h0 : w_fifo_rdata;
    assign overflow              = r_overflow;
    assign drop_count            = r_drop_count;

endmodule
`default_nettype wire
